auto_decision: RTL and testbench
================================

// Module: auto_decision
// PURPOSE
//  Autopilot decision unit: the initiator that drives the auto-turn executor.
//  - Reads four obstacle detectors and drives the car forward.
//  - At a junction or dead end, chooses one manoeuvre (left, right or back) by the wall-follow rule.
//  - Issues a one-cycle trigger, waits for the executor's is_turning acknowledge to rise and fall,
//    then drives forward for a settle interval so the car clears the junction.
// PARAMETERS
//  DEBOUNCE_TIME   10   cycles a detector must be stable before its filtered value changes (20 ms at 500 Hz)
//  ACK_TIMEOUT     4    cycles after a trigger within which is_turning must rise
//  SETTLE_TIME     250  cycles of forced forward drive after a turn completes (0.5 s)
// PORTS
//  clk              in   1  system clock, 500 Hz
//  rst_n            in   1  asynchronous reset, active low
//  enable           in   1  autopilot mode select; low forces IDLE
//  detector_front   in   1  1 = obstacle ahead
//  detector_left    in   1  1 = wall on left
//  detector_right   in   1  1 = wall on right
//  detector_back    in   1  1 = obstacle behind (informational only; no effect on decisions)
//  is_turning       in   1  turn-executor busy flag (acknowledge)
//  trigger_turn_left  out 1  one-cycle request: 90-degree left turn
//  trigger_turn_right out 1  one-cycle request: 90-degree right turn
//  trigger_turn_back  out 1  one-cycle request: 180-degree turn
//  move_forward     out  1  drive motors forward
//  ack_fault        out  1  sticky: a trigger was not acknowledged within ACK_TIMEOUT
// BEHAVIOUR
//  - Reset and enable=0: all outputs 0 (ack_fault is cleared only by reset), state IDLE, counters 0.
//    Reset or enable drop mid-turn aborts at once; is_turning is ignored until the next decision.
//  - Detectors are filtered first. Decisions use only the filtered values fl, ff, fr (1 = open).
//  - Triggers are registered and mutually one-hot. Each is high for exactly one cycle.
//  - States:
//    IDLE: enable=1 -> FORWARD next cycle.
//    FORWARD: move_forward=1.
//      Left-hand rule, in priority order:
//        fl              -> TRIGGER(left)
//        else ff         -> stay in FORWARD
//        else fr         -> TRIGGER(right)
//        else (dead end) -> TRIGGER(back)
//    TRIGGER: move_forward=0; the selected trigger=1 for this one cycle; ack counter cleared -> WAIT_ACK.
//    WAIT_ACK: when is_turning=1 -> TURNING.
//      If the counter reaches ACK_TIMEOUT-1 with no is_turning: set ack_fault -> FORWARD.
//    TURNING: move_forward=0; when is_turning=0 -> SETTLE, settle counter cleared.
//    SETTLE: move_forward=1; side openings are ignored.
//      ff=0 -> FORWARD immediately (re-decide at once).
//      Counter reaching SETTLE_TIME-1 -> FORWARD.
//  - Latency: an opening seen in FORWARD produces a trigger 1 cycle later.
//    The executor asserts is_turning the cycle after the trigger.
//  - is_turning already high when entering WAIT_ACK counts as the acknowledge.
//  - Counters are 32 bit and saturate; they never wrap.
// CONFIGURATION
//  RIGHT_HAND_RULE_EN defined: right-hand rule instead.
//    Priority is fr -> right, else ff -> forward, else fl -> left, else back.
//  Not defined: left-hand rule as in BEHAVIOUR. Ports are identical in both builds.
// STRUCTURE
//  - auto_pkg (shared with auto_turning): state encodings IDLE/FORWARD/TRIGGER/WAIT_ACK/TURNING/SETTLE,
//    and the default timing constants.
//  - Sub-module detector_debounce(clk, rst_n, raw, filtered), parameter DEBOUNCE_TIME.
//    Instantiated four times. filtered resets to 1 (obstacle), so no decision is made before the first
//    stable reading.
// TESTING
//  1 rst_n=0 mid-TURNING -> all outputs 0 asynchronously; after release with enable=1: FORWARD, move_forward=1.
//  2 Front clear, left opens for 10 cycles -> exactly one trigger_turn_left pulse.
//    Ack 1 cycle later, is_turning held for 450 cycles -> move_forward=1 for 250 cycles, then FORWARD.
//  3 All of left, front and right blocked -> trigger_turn_back.
//    Left opening for only 5 cycles (glitch) -> no trigger.
//  4 Trigger with is_turning held at 0 -> ack_fault=1 after 4 cycles, back to FORWARD.
//    ack_fault stays 1 until reset.
//  5 In SETTLE, front blocks at cycle 100 -> leaves SETTLE next cycle and issues the decided trigger.
//  6 RIGHT_HAND_RULE_EN build, left and right both open -> trigger_turn_right, never trigger_turn_left.

Source files
------------

// File: rtl/auto_pkg.sv
// Shared types and timing defaults for the autopilot decision and turn executor.
// State encodings, turn request bundle and a saturating counter helper.
package auto_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FORWARD,
        TRIGGER,
        WAIT_ACK,
        TURNING,
        SETTLE
    } state_t;

    typedef struct packed {
        logic left;
        logic right;
        logic back;
    } turn_t;

    localparam int unsigned CNT_W             = 32;
    localparam int unsigned DEBOUNCE_TIME_DEF = 10;
    localparam int unsigned ACK_TIMEOUT_DEF   = 4;
    localparam int unsigned SETTLE_TIME_DEF   = 250;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/detector_debounce.sv
// Debounce filter for one obstacle detector.
// Output resets to 1 (obstacle) and follows raw after DEBOUNCE_TIME stable samples.
module detector_debounce
    import auto_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TIME = DEBOUNCE_TIME_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filtered
);

    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples that disagree with the filtered value.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (raw != filt_q) begin
            if (cnt_q >= CNT_W'(DEBOUNCE_TIME - 1)) begin
                filt_d = raw;
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filtered = filt_q;

endmodule

// File: rtl/auto_decision.sv
// Autopilot decision unit: picks a manoeuvre at junctions and hands it to the turn executor.
// Build option RIGHT_HAND_RULE_EN selects the right-hand wall-follow rule.
module auto_decision
    import auto_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TIME = DEBOUNCE_TIME_DEF,
    parameter int unsigned ACK_TIMEOUT   = ACK_TIMEOUT_DEF,
    parameter int unsigned SETTLE_TIME   = SETTLE_TIME_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic detector_front,
    input  logic detector_left,
    input  logic detector_right,
    input  logic detector_back,
    input  logic is_turning,
    output logic trigger_turn_left,
    output logic trigger_turn_right,
    output logic trigger_turn_back,
    output logic move_forward,
    output logic ack_fault
);

    logic df;
    logic dl;
    logic dr;
    logic db_unused;

    detector_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_deb_front (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (detector_front),
        .filtered (df)
    );

    detector_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_deb_left (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (detector_left),
        .filtered (dl)
    );

    detector_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_deb_right (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (detector_right),
        .filtered (dr)
    );

    detector_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_deb_back (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (detector_back),
        .filtered (db_unused)
    );

    logic ff;
    logic fl;
    logic fr;

    assign ff = ~df;
    assign fl = ~dl;
    assign fr = ~dr;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    turn_t            trig_q;
    turn_t            trig_d;
    logic             fault_q;
    logic             fault_d;
    turn_t            pick;

    // Wall-follow rule: all-zero pick means keep driving forward.
    always_comb begin
        pick = '0;
`ifdef RIGHT_HAND_RULE_EN
        if (fr) begin
            pick.right = 1'b1;
        end else if (ff) begin
            pick = '0;
        end else if (fl) begin
            pick.left = 1'b1;
        end else begin
            pick.back = 1'b1;
        end
`else
        if (fl) begin
            pick.left = 1'b1;
        end else if (ff) begin
            pick = '0;
        end else if (fr) begin
            pick.right = 1'b1;
        end else begin
            pick.back = 1'b1;
        end
`endif
    end

    // Next-state logic; the shared counter times both the ack wait and the settle drive.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = '0;
        fault_d = fault_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FORWARD;
                end
                FORWARD: begin
                    if (pick != '0) begin
                        state_d = TRIGGER;
                        trig_d  = pick;
                    end
                end
                TRIGGER: begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end
                WAIT_ACK: begin
                    if (is_turning) begin
                        state_d = TURNING;
                    end else if (cnt_q >= CNT_W'(ACK_TIMEOUT - 1)) begin
                        fault_d = 1'b1;
                        state_d = FORWARD;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                TURNING: begin
                    if (!is_turning) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
                SETTLE: begin
                    if (!ff) begin
                        state_d = FORWARD;
                    end else if (cnt_q >= CNT_W'(SETTLE_TIME - 1)) begin
                        state_d = FORWARD;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter, trigger and fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            fault_q <= fault_d;
        end
    end

    assign trigger_turn_left  = trig_q.left;
    assign trigger_turn_right = trig_q.right;
    assign trigger_turn_back  = trig_q.back;
    assign move_forward       = (state_q == FORWARD) || (state_q == SETTLE);
    assign ack_fault          = fault_q;

endmodule

// File: tb/tb_auto_decision.sv
// Directed testbench for auto_decision.
// Expected values are hand-derived cycle counts from the behavioural description.
module tb_auto_decision;

    logic clk;
    logic rst_n;
    logic enable;
    logic detector_front;
    logic detector_left;
    logic detector_right;
    logic detector_back;
    logic is_turning;
    logic trigger_turn_left;
    logic trigger_turn_right;
    logic trigger_turn_back;
    logic move_forward;
    logic ack_fault;

    int checks;
    int failures;

    auto_decision dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .detector_front     (detector_front),
        .detector_left      (detector_left),
        .detector_right     (detector_right),
        .detector_back      (detector_back),
        .is_turning         (is_turning),
        .trigger_turn_left  (trigger_turn_left),
        .trigger_turn_right (trigger_turn_right),
        .trigger_turn_back  (trigger_turn_back),
        .move_forward       (move_forward),
        .ack_fault          (ack_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] trig();
        return {29'd0, trigger_turn_left, trigger_turn_right, trigger_turn_back};
    endfunction

    logic        seen;
    logic [31:0] exp_pick;

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        enable         = 1'b0;
        detector_front = 1'b0;
        detector_left  = 1'b1;
        detector_right = 1'b1;
        detector_back  = 1'b0;
        is_turning     = 1'b0;
        step(2);
        chk("rst_mf", move_forward, 0);
        chk("rst_trig", trig(), 0);
        chk("rst_fault", ack_fault, 0);

        rst_n = 1'b1;
        step(12);
        chk("idle_mf", move_forward, 0);
        enable = 1'b1;
        step(1);
        chk("fwd_mf", move_forward, 1);
        step(1);
        chk("fwd_stay", trig(), 0);

        // left opening, turn with long is_turning, full settle
        detector_left = 1'b0;
        step(10);
        chk("left_pre", trig(), 0);
        chk("left_pre_mf", move_forward, 1);
        step(1);
        chk("left_trig", trig(), 3'b100);
        chk("left_trig_mf", move_forward, 0);
        detector_left = 1'b1;
        is_turning    = 1'b1;
        step(1);
        chk("left_pulse_end", trig(), 0);
        step(1);
        chk("turning_mf", move_forward, 0);
        step(448);
        chk("turning_long_mf", move_forward, 0);
        chk("turning_long_trig", trig(), 0);
        is_turning = 1'b0;
        step(1);
        chk("settle_mf", move_forward, 1);
        detector_left = 1'b0;
        step(249);
        chk("settle_end_trig", trig(), 0);
        chk("settle_end_mf", move_forward, 1);
        step(1);
        chk("post_settle_trig", trig(), 0);
        step(1);
        chk("post_settle_left", trig(), 3'b100);

        // no acknowledge -> sticky fault
        detector_left = 1'b1;
        step(1);
        chk("ack_wait0", ack_fault, 0);
        step(3);
        chk("ack_wait3", ack_fault, 0);
        step(1);
        chk("ack_fault_set", ack_fault, 1);
        chk("ack_fault_mf", move_forward, 1);
        step(1);
        chk("ack_fault_redecide", trig(), 3'b100);
        enable = 1'b0;
        step(1);
        chk("dis_mf", move_forward, 0);
        chk("dis_trig", trig(), 0);
        chk("dis_fault_sticky", ack_fault, 1);
        step(12);

        // glitch on left is filtered out
        enable = 1'b1;
        step(1);
        chk("glitch_fwd", move_forward, 1);
        detector_left = 1'b0;
        step(5);
        detector_left = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (trig() != 0) seen = 1'b1;
        end
        chk("glitch_no_trig", seen, 0);

        // dead end -> back
        detector_front = 1'b1;
        step(10);
        chk("dead_pre", trig(), 0);
        step(1);
        chk("dead_back", trig(), 3'b001);
        chk("dead_mf", move_forward, 0);
        detector_front = 1'b0;
        is_turning     = 1'b1;
        step(2);
        chk("back_turning_mf", move_forward, 0);
        step(20);
        is_turning = 1'b0;
        step(1);
        chk("settle2_mf", move_forward, 1);

        // front blocks during settle at cycle 100, right open
        step(90);
        detector_front = 1'b1;
        detector_right = 1'b0;
        step(10);
        chk("settle_block_mf", move_forward, 1);
        chk("settle_block_trig", trig(), 0);
        step(1);
        chk("settle_exit_trig", trig(), 0);
        chk("settle_exit_mf", move_forward, 1);
        step(1);
        chk("settle_exit_right", trig(), 3'b010);
        is_turning = 1'b1;
        step(2);
        chk("pre_rst_turning_mf", move_forward, 0);

        // asynchronous reset mid-turn
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mf", move_forward, 0);
        chk("async_rst_trig", trig(), 0);
        chk("async_rst_fault", ack_fault, 0);
        rst_n      = 1'b1;
        is_turning = 1'b0;
        step(1);
        chk("post_rst_fwd", move_forward, 1);

        // both sides open: rule picks the preferred side
        enable         = 1'b0;
        detector_front = 1'b0;
        detector_left  = 1'b0;
        detector_right = 1'b0;
        step(12);
        enable = 1'b1;
        step(1);
        chk("both_fwd", trig(), 0);
        step(1);
`ifdef RIGHT_HAND_RULE_EN
        exp_pick = 32'b010;
`else
        exp_pick = 32'b100;
`endif
        chk("both_pick", trig(), exp_pick);
        chk("both_fault", ack_fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
